// File: rtl/vote_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vote_link_pkg                                          |
// | Description : Shared types and constants for the vote link           |
// |               initiator (word width, FSM state encodings, error     |
// |               flag bit positions).                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package vote_link_pkg;

  // Vote / result word width, fixed by the voter protocol.
  localparam int VOTE_W = 4;

  // Bit positions inside the sticky err vector.
  localparam int ERR_TX = 0;
  localparam int ERR_RX = 1;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_REL  = 2'd2
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_REQ  = 2'd1,
    RX_REL  = 2'd2
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/vote_link_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vote_link_fifo                                         |
// | Description : Small synchronous FIFO with occupancy count. Pushes    |
// |               into a full FIFO are accepted only alongside a pop;    |
// |               pops from an empty FIFO are ignored.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module vote_link_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage, power-of-two pointers that wrap naturally, and occupancy count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/vote_link_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vote_link_initiator                                    |
// | Description : Far-end partner of the voting controller. Sends host   |
// |               vote words over the RTR/CTR four-phase handshake and   |
// |               fetches results over the RTS/CTS handshake into a      |
// |               result FIFO. Optional phase timeouts are enabled with  |
// |               the VOTE_LINK_TIMEOUT_EN macro.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module vote_link_initiator
  import vote_link_pkg::*;
#(
  parameter int RESULT_DEPTH   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [VOTE_W-1:0] cmd_data,
  input  logic              rx_enable,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [VOTE_W-1:0] res_data,
  output logic              rtr,
  input  logic              ctr,
  output logic [VOTE_W-1:0] v_in,
  output logic              rts,
  input  logic              cts,
  input  logic [VOTE_W-1:0] v_out,
  output logic              busy,
  output logic [1:0]        err,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(RESULT_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RESULT_DEPTH);

  tx_state_t         tx_state, tx_next;
  rx_state_t         rx_state, rx_next;
  logic              rtr_next;
  logic [VOTE_W-1:0] v_in_next;
  logic              rts_next;
  logic              rx_push;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

`ifdef VOTE_LINK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tx_cnt;
  logic [TMO_W-1:0] rx_cnt;
  logic             tx_tmo;
  logic             rx_tmo;
`endif

  assign cmd_ready = (tx_state == TX_IDLE);
  assign res_valid = ~fifo_empty;
  assign busy      = (tx_state != TX_IDLE) | (rx_state != RX_IDLE);

  // TX next-state: accept a word, hold RTR until CTR, then wait for CTR release.
  always_comb begin
    tx_next   = tx_state;
    rtr_next  = rtr;
    v_in_next = v_in;
`ifdef VOTE_LINK_TIMEOUT_EN
    tx_tmo    = 1'b0;
`endif
    case (tx_state)
      TX_IDLE: begin
        if (cmd_valid) begin
          v_in_next = cmd_data;
          rtr_next  = 1'b1;
          tx_next   = TX_REQ;
        end
      end
      TX_REQ: begin
        if (ctr) begin
          rtr_next = 1'b0;
          tx_next  = TX_REL;
        end
`ifdef VOTE_LINK_TIMEOUT_EN
        else if (tx_cnt == TMO_LAST) begin
          rtr_next = 1'b0;
          tx_next  = TX_IDLE;
          tx_tmo   = 1'b1;
        end
`endif
      end
      TX_REL: begin
        if (!ctr) begin
          tx_next = TX_IDLE;
        end
`ifdef VOTE_LINK_TIMEOUT_EN
        else if (tx_cnt == TMO_LAST) begin
          tx_next = TX_IDLE;
          tx_tmo  = 1'b1;
        end
`endif
      end
      default: begin
        rtr_next = 1'b0;
        tx_next  = TX_IDLE;
      end
    endcase
  end

  // RX next-state: request only when a FIFO slot is free, push on CTS.
  always_comb begin
    rx_next  = rx_state;
    rts_next = rts;
    rx_push  = 1'b0;
`ifdef VOTE_LINK_TIMEOUT_EN
    rx_tmo   = 1'b0;
`endif
    case (rx_state)
      RX_IDLE: begin
        if (rx_enable && (fifo_count < DEPTH_C)) begin
          rts_next = 1'b1;
          rx_next  = RX_REQ;
        end
      end
      RX_REQ: begin
        if (cts) begin
          rx_push  = 1'b1;
          rts_next = 1'b0;
          rx_next  = RX_REL;
        end
`ifdef VOTE_LINK_TIMEOUT_EN
        else if (rx_cnt == TMO_LAST) begin
          rts_next = 1'b0;
          rx_next  = RX_IDLE;
          rx_tmo   = 1'b1;
        end
`endif
      end
      RX_REL: begin
        if (!cts) begin
          rx_next = RX_IDLE;
        end
`ifdef VOTE_LINK_TIMEOUT_EN
        else if (rx_cnt == TMO_LAST) begin
          rx_next = RX_IDLE;
          rx_tmo  = 1'b1;
        end
`endif
      end
      default: begin
        rts_next = 1'b0;
        rx_next  = RX_IDLE;
      end
    endcase
  end

  // State and registered handshake outputs for both channels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= TX_IDLE;
      rx_state <= RX_IDLE;
      rtr      <= 1'b0;
      rts      <= 1'b0;
      v_in     <= '0;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
      rtr      <= rtr_next;
      rts      <= rts_next;
      v_in     <= v_in_next;
    end
  end

`ifdef VOTE_LINK_TIMEOUT_EN
  // Phase counters restart on every state change and run while not idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_next != tx_state) tx_cnt <= '0;
      else if (tx_state != TX_IDLE) tx_cnt <= tx_cnt + 1'b1;
      if (rx_next != rx_state) rx_cnt <= '0;
      else if (rx_state != RX_IDLE) rx_cnt <= rx_cnt + 1'b1;
    end
  end

  // Sticky timeout flags; a new timeout beats a simultaneous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err <= '0;
    end else begin
      if (tx_tmo) err[ERR_TX] <= 1'b1;
      else if (err_clr) err[ERR_TX] <= 1'b0;
      if (rx_tmo) err[ERR_RX] <= 1'b1;
      else if (err_clr) err[ERR_RX] <= 1'b0;
    end
  end
`else
  logic unused_tmo;
  assign err        = 2'b00;
  assign unused_tmo = ^{err_clr, 1'(TIMEOUT_CYCLES)};
`endif

  // Space is judged from the count, so the full flag is not needed here.
  logic unused_full;
  assign unused_full = fifo_full;

  vote_link_fifo #(
    .DEPTH (RESULT_DEPTH),
    .WIDTH (VOTE_W)
  ) u_result_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rx_push),
    .push_data (v_out),
    .pop       (res_valid & res_ready),
    .pop_data  (res_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_vote_link_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_vote_link_initiator                                 |
// | Description : Self-checking bench for vote_link_initiator: per-cycle |
// |               vector table for the basic TX/RX handshakes, plus      |
// |               hand sequences for FIFO corners, concurrency, reset    |
// |               and (with VOTE_LINK_TIMEOUT_EN) timeouts.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_vote_link_initiator;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_data;
  logic       rx_enable;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       rtr;
  logic       ctr;
  logic [3:0] v_in;
  logic       rts;
  logic       cts;
  logic [3:0] v_out;
  logic       busy;
  logic [1:0] err;
  logic       err_clr;

  int errors = 0;
  int checks = 0;

  vote_link_initiator #(
    .RESULT_DEPTH   (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rx_enable (rx_enable),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .rtr       (rtr),
    .ctr       (ctr),
    .v_in      (v_in),
    .rts       (rts),
    .cts       (cts),
    .v_out     (v_out),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clock = ~clock;

  // One row: outputs expected at this falling edge, then inputs for the next rise.
  typedef struct {
    logic       cv;
    logic [3:0] cd;
    logic       ack_r;
    logic       rxe;
    logic       ack_s;
    logic [3:0] vo;
    logic       rr;
    logic       e_rtr;
    logic [3:0] e_vin;
    logic       e_crdy;
    logic       e_rts;
    logic       e_rv;
    logic [3:0] e_rd;
    logic       e_busy;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_data = 4'h0; ctr = 1'b0; rx_enable = 1'b0;
    cts = 1'b0; v_out = 4'h0; res_ready = 1'b0; err_clr = 1'b0;
  endtask

  // One full result fetch; optionally pops the head in the push cycle.
  task automatic do_rx(input logic [3:0] val, input logic pop_same);
    bit seen = 1'b0;
    @(negedge clock);
    rx_enable = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (rts) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      errors++;
      $display("FAIL rx_wait_rts: got no rts expected rts within 10 cycles");
    end
    rx_enable = 1'b0;
    cts = 1'b1; v_out = val; res_ready = pop_same;
    @(negedge clock);
    cts = 1'b0; res_ready = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    //          cv  cd   ctr  rxe  cts  vo  rr   rtr vin crdy rts rv  rd  busy
    vecs[0]  = '{1, 4'hA, 0,   0,   0, 4'h0, 0,   0, 4'h0, 1,  0,  0, 4'h0, 0};
    vecs[1]  = '{0, 4'h0, 0,   0,   0, 4'h0, 0,   1, 4'hA, 0,  0,  0, 4'h0, 1};
    vecs[2]  = '{0, 4'h0, 0,   0,   0, 4'h0, 0,   1, 4'hA, 0,  0,  0, 4'h0, 1};
    vecs[3]  = '{0, 4'h0, 0,   0,   0, 4'h0, 0,   1, 4'hA, 0,  0,  0, 4'h0, 1};
    vecs[4]  = '{0, 4'h0, 1,   0,   0, 4'h0, 0,   1, 4'hA, 0,  0,  0, 4'h0, 1};
    vecs[5]  = '{0, 4'h0, 1,   0,   0, 4'h0, 0,   0, 4'hA, 0,  0,  0, 4'h0, 1};
    vecs[6]  = '{0, 4'h0, 0,   0,   0, 4'h0, 0,   0, 4'hA, 0,  0,  0, 4'h0, 1};
    vecs[7]  = '{0, 4'h0, 0,   1,   0, 4'h0, 0,   0, 4'hA, 1,  0,  0, 4'h0, 0};
    vecs[8]  = '{0, 4'h0, 0,   1,   1, 4'h5, 0,   0, 4'hA, 1,  1,  0, 4'h0, 1};
    vecs[9]  = '{0, 4'h0, 0,   1,   0, 4'h5, 0,   0, 4'hA, 1,  0,  1, 4'h5, 1};
    vecs[10] = '{0, 4'h0, 0,   1,   0, 4'h0, 0,   0, 4'hA, 1,  0,  1, 4'h5, 0};
    vecs[11] = '{0, 4'h0, 0,   1,   1, 4'h3, 0,   0, 4'hA, 1,  1,  1, 4'h5, 1};
    vecs[12] = '{0, 4'h0, 0,   1,   0, 4'h3, 0,   0, 4'hA, 1,  0,  1, 4'h5, 1};
    vecs[13] = '{0, 4'h0, 0,   1,   0, 4'h0, 0,   0, 4'hA, 1,  0,  1, 4'h5, 0};
    vecs[14] = '{0, 4'h0, 0,   1,   0, 4'h0, 0,   0, 4'hA, 1,  0,  1, 4'h5, 0};
    vecs[15] = '{0, 4'h0, 0,   1,   0, 4'h0, 1,   0, 4'hA, 1,  0,  1, 4'h5, 0};
    vecs[16] = '{0, 4'h0, 0,   0,   0, 4'h0, 1,   0, 4'hA, 1,  0,  1, 4'h3, 0};
    vecs[17] = '{0, 4'h0, 0,   0,   0, 4'h0, 0,   0, 4'hA, 1,  0,  0, 4'h0, 0};

    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      chk($sformatf("v%0d_rtr", i), 32'(rtr), 32'(vecs[i].e_rtr));
      chk($sformatf("v%0d_vin", i), 32'(v_in), 32'(vecs[i].e_vin));
      chk($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_crdy));
      chk($sformatf("v%0d_rts", i), 32'(rts), 32'(vecs[i].e_rts));
      chk($sformatf("v%0d_res_valid", i), 32'(res_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("v%0d_res_data", i), 32'(res_data), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_err", i), 32'(err), 32'd0);
      cmd_valid = vecs[i].cv;  cmd_data = vecs[i].cd;  ctr = vecs[i].ack_r;
      rx_enable = vecs[i].rxe; cts = vecs[i].ack_s;     v_out = vecs[i].vo;
      res_ready = vecs[i].rr;
    end

    // FIFO corners: push with simultaneous pop at count=1, then fill, then drain.
    do_rx(4'h1, 1'b0);
    chk("fifo_one_valid", 32'(res_valid), 32'd1);
    chk("fifo_one_head", 32'(res_data), 32'h1);
    do_rx(4'h2, 1'b1);
    chk("pushpop_valid", 32'(res_valid), 32'd1);
    chk("pushpop_head", 32'(res_data), 32'h2);
    do_rx(4'h3, 1'b0);
    chk("full_head", 32'(res_data), 32'h2);
    rx_enable = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clock);
      chk("full_no_rts", 32'(rts), 32'd0);
    end
    rx_enable = 1'b0;
    res_ready = 1'b1;
    @(negedge clock);
    chk("drain1_head", 32'(res_data), 32'h3);
    chk("drain1_valid", 32'(res_valid), 32'd1);
    @(negedge clock);
    chk("drain2_valid", 32'(res_valid), 32'd0);
    @(negedge clock);
    res_ready = 1'b0;
    chk("empty_pop_valid", 32'(res_valid), 32'd0);
    do_rx(4'h4, 1'b0);
    chk("after_empty_pop_head", 32'(res_data), 32'h4);
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    chk("after_empty_pop_drained", 32'(res_valid), 32'd0);

    // Concurrent TX of F and RX of 9.
    cmd_valid = 1'b1; cmd_data = 4'hF; rx_enable = 1'b1;
    @(negedge clock);
    chk("conc_rtr", 32'(rtr), 32'd1);
    chk("conc_rts", 32'(rts), 32'd1);
    chk("conc_vin", 32'(v_in), 32'hF);
    chk("conc_busy_a", 32'(busy), 32'd1);
    cmd_valid = 1'b0; rx_enable = 1'b0; ctr = 1'b1; cts = 1'b1; v_out = 4'h9;
    @(negedge clock);
    chk("conc_rtr_low", 32'(rtr), 32'd0);
    chk("conc_rts_low", 32'(rts), 32'd0);
    chk("conc_res", 32'(res_data), 32'h9);
    chk("conc_busy_b", 32'(busy), 32'd1);
    ctr = 1'b0;
    @(negedge clock);
    chk("conc_tx_idle", 32'(cmd_ready), 32'd1);
    chk("conc_busy_c", 32'(busy), 32'd1);
    cts = 1'b0;
    @(negedge clock);
    chk("conc_busy_d", 32'(busy), 32'd0);
    chk("conc_vin_hold", 32'(v_in), 32'hF);

    // Asynchronous reset in the middle of both handshakes, one result buffered.
    cmd_valid = 1'b1; cmd_data = 4'h2; rx_enable = 1'b1;
    @(negedge clock);
    chk("pre_reset_rtr", 32'(rtr), 32'd1);
    chk("pre_reset_rts", 32'(rts), 32'd1);
    chk("pre_reset_valid", 32'(res_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_rtr", 32'(rtr), 32'd0);
    chk("rst_rts", 32'(rts), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_vin", 32'(v_in), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    idle_inputs();
    @(negedge clock);
    reset_n = 1'b1;

`ifdef VOTE_LINK_TIMEOUT_EN
    begin
      int hi = 0;
      cmd_valid = 1'b1; cmd_data = 4'h7;
      @(negedge clock);
      cmd_valid = 1'b0;
      for (int n = 0; n < 30; n++) begin
        if (!rtr) break;
        hi++;
        @(negedge clock);
      end
      chk("tmo_tx_rtr_cycles", 32'(hi), 32'd8);
      chk("tmo_tx_err", 32'(err), 32'b01);
      chk("tmo_tx_cmd_ready", 32'(cmd_ready), 32'd1);
      err_clr = 1'b1;
      @(negedge clock);
      err_clr = 1'b0;
      chk("tmo_clr", 32'(err), 32'b00);
      rx_enable = 1'b1;
      repeat (12) @(negedge clock);
      rx_enable = 1'b0;
      chk("tmo_rx_err", 32'(err[1]), 32'd1);
      chk("tmo_rx_no_push", 32'(res_valid), 32'd0);
    end
`else
    cmd_valid = 1'b1; cmd_data = 4'h6;
    @(negedge clock);
    cmd_valid = 1'b0;
    err_clr = 1'b1;
    repeat (20) @(negedge clock);
    err_clr = 1'b0;
    chk("stall_rtr", 32'(rtr), 32'd1);
    chk("stall_vin", 32'(v_in), 32'h6);
    chk("stall_err", 32'(err), 32'd0);
    ctr = 1'b1;
    @(negedge clock);
    chk("stall_release", 32'(rtr), 32'd0);
    ctr = 1'b0;
    @(negedge clock);
    chk("stall_idle", 32'(cmd_ready), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
